// File: rtl/rf_wr_arb_if.sv
// Bundle between the writeback requesters, the arbiter and the register file write port.
interface rf_wr_arb_if;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;

  logic              req0_valid;
  logic [REG_W-1:0]  req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [REG_W-1:0]  req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              write;
  logic [REG_W-1:0]  writeregsel;
  logic [DATA_W-1:0] writedata;
  logic              idle;
  logic              err;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  write, writeregsel, writedata, idle, err
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output write, writeregsel, writedata, idle, err
  );
endinterface

// File: rtl/rf_wr_arb.sv
// Round-robin arbiter sharing the single register-file write port between
// ALU writeback (requester 0) and load return (requester 1), each with a small FIFO.
module rf_wr_arb #(
  parameter int unsigned DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  rf_wr_arb_if.slave  bus
);
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [REG_W-1:0]  rsel;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t         in_e      [NREQ];
  wr_entry_t         mem_q     [NREQ][DEPTH];
  logic [PTR_W-1:0]  wptr_q    [NREQ];
  logic [PTR_W-1:0]  wptr_d    [NREQ];
  logic [PTR_W-1:0]  rptr_q    [NREQ];
  logic [PTR_W-1:0]  rptr_d    [NREQ];
  logic [CNT_W-1:0]  cnt_q     [NREQ];
  logic [CNT_W-1:0]  cnt_d     [NREQ];
  logic [NREQ-1:0]   in_valid;
  logic [NREQ-1:0]   ready_c;
  logic [NREQ-1:0]   push_c;
  logic [NREQ-1:0]   pop_c;
  logic [NREQ-1:0]   nonempty_c;
  logic              gnt_valid_c;
  logic              gnt_sel_c;
  wr_entry_t         head_c;
  logic              last_q, last_d;
  logic              write_q, write_d;
  logic [REG_W-1:0]  wsel_q, wsel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  assign in_valid = {bus.req1_valid, bus.req0_valid};
  assign in_e[0]  = {bus.req0_reg, bus.req0_data};
  assign in_e[1]  = {bus.req1_reg, bus.req1_data};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and grant: ready looks only at the registered count.
  always_comb begin
    nonempty_c  = '0;
    ready_c     = '0;
    push_c      = '0;
    pop_c       = '0;
    for (int n = 0; n < NREQ; n++) begin
      nonempty_c[n] = (cnt_q[n] != '0);
      ready_c[n]    = !rst && (cnt_q[n] < CNT_W'(DEPTH));
      push_c[n]     = in_valid[n] && ready_c[n];
    end
    gnt_valid_c = |nonempty_c;
    gnt_sel_c   = (&nonempty_c) ? ~last_q : nonempty_c[1];
    if (gnt_valid_c) pop_c[gnt_sel_c] = 1'b1;
    head_c = mem_q[gnt_sel_c][rptr_q[gnt_sel_c]];
  end

  // Next-state for FIFO bookkeeping and the output stage.
  always_comb begin
    for (int n = 0; n < NREQ; n++) begin
      wptr_d[n] = wptr_q[n];
      rptr_d[n] = rptr_q[n];
      cnt_d[n]  = cnt_q[n];
    end
    last_d  = last_q;
    write_d = gnt_valid_c;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    err_d   = !rst && |(in_valid & ~ready_c);

    for (int n = 0; n < NREQ; n++) begin
      if (push_c[n]) wptr_d[n] = ptr_inc(wptr_q[n]);
      if (pop_c[n])  rptr_d[n] = ptr_inc(rptr_q[n]);
      case ({push_c[n], pop_c[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + CNT_W'(1);
        2'b01:   cnt_d[n] = cnt_q[n] - CNT_W'(1);
        default: cnt_d[n] = cnt_q[n];
      endcase
    end

    if (gnt_valid_c) begin
      wsel_d  = head_c.rsel;
      wdata_d = head_c.data;
      last_d  = gnt_sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREQ; n++) begin
        wptr_q[n] <= '0;
        rptr_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
      last_q  <= 1'b1;
      write_q <= 1'b0;
      wsel_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int n = 0; n < NREQ; n++) begin
        wptr_q[n] <= wptr_d[n];
        rptr_q[n] <= rptr_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
      last_q  <= last_d;
      write_q <= write_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Entry storage needs no reset; push is already blocked while rst is high.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NREQ; n++) begin
      if (push_c[n]) mem_q[n][wptr_q[n]] <= in_e[n];
    end
  end

  assign bus.req0_ready  = ready_c[0];
  assign bus.req1_ready  = ready_c[1];
  assign bus.write       = write_q;
  assign bus.writeregsel = wsel_q;
  assign bus.writedata   = wdata_q;
  assign bus.err         = err_q;
  assign bus.idle        = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !write_q;
endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed and random bench for rf_wr_arb against a queue-based reference model.
module tb_rf_wr_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wr_arb_if bus();
  rf_wr_arb dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [18:0] mq0[$];
  logic [18:0] mq1[$];
  int          last_g;
  logic        e_write;
  logic [2:0]  e_wsel;
  logic [15:0] e_wdata;
  logic        e_err;
  logic [15:0] rf_exp [8];

  // Register-file stub fed by the DUT, plus a log of issued writes
  logic [15:0] rf_obs [8];
  logic [18:0] wlog[$];
  logic [18:0] f0[$];
  logic [18:0] f1[$];

  always @(posedge clk) begin
    if (bus.write === 1'b1) begin
      rf_obs[bus.writeregsel] <= bus.writedata;
      wlog.push_back({bus.writeregsel, bus.writedata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    e_write = 1'b0;
    e_wsel  = '0;
    e_wdata = '0;
    e_err   = 1'b0;
    last_g  = 1;
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit r, input bit v0, input logic [18:0] x0,
                      input bit v1, input logic [18:0] x1);
    bit rdy0, rdy1, g0, g1;
    rst            = r;
    bus.req0_valid = v0;
    {bus.req0_reg, bus.req0_data} = x0;
    bus.req1_valid = v1;
    {bus.req1_reg, bus.req1_data} = x1;
    #1;
    rdy0 = !r && (mq0.size() < 2);
    rdy1 = !r && (mq1.size() < 2);
    chk("req0_ready", 32'(bus.req0_ready), 32'(rdy0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(rdy1));
    chk("idle", 32'(bus.idle), 32'(mq0.size() == 0 && mq1.size() == 0 && !e_write));

    if (e_write) rf_exp[e_wsel] = e_wdata;
    if (r) begin
      model_reset();
    end else begin
      g0 = (mq0.size() > 0) && (mq1.size() == 0 || last_g == 1);
      g1 = (mq1.size() > 0) && !g0;
      if (g0) begin
        {e_wsel, e_wdata} = mq0.pop_front();
        e_write = 1'b1;
        last_g  = 0;
      end else if (g1) begin
        {e_wsel, e_wdata} = mq1.pop_front();
        e_write = 1'b1;
        last_g  = 1;
      end else begin
        e_write = 1'b0;
      end
      e_err = (v0 && !rdy0) || (v1 && !rdy1);
      if (v0 && rdy0) mq0.push_back(x0);
      if (v1 && rdy1) mq1.push_back(x1);
    end

    @(posedge clk);
    #1;
    chk("write", 32'(bus.write), 32'(e_write));
    chk("writeregsel", 32'(bus.writeregsel), 32'(e_wsel));
    chk("writedata", 32'(bus.writedata), 32'(e_wdata));
    chk("err", 32'(bus.err), 32'(e_err));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Feed queued entries, presenting valid only when the buffer has room.
  task automatic run_feed(input int n);
    bit a0, a1;
    logic [18:0] x0, x1;
    for (int i = 0; i < n; i++) begin
      a0 = (f0.size() > 0) && (mq0.size() < 2);
      a1 = (f1.size() > 0) && (mq1.size() < 2);
      x0 = a0 ? f0[0] : '0;
      x1 = a1 ? f1[0] : '0;
      step(1'b0, a0, x0, a1, x1);
      if (a0) void'(f0.pop_front());
      if (a1) void'(f1.pop_front());
    end
  endtask

  initial begin
    logic [18:0] exp_seq [6];
    int hits;
    bit r, v0, v1;

    for (int i = 0; i < 8; i++) begin
      rf_obs[i] = '0;
      rf_exp[i] = '0;
    end

    // Reset held two cycles with both valids high
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_reg   = 3'd1;
    bus.req0_data  = 16'hdead;
    bus.req1_valid = 1'b1;
    bus.req1_reg   = 3'd2;
    bus.req1_data  = 16'hbeef;
    @(posedge clk);
    #1;
    model_reset();
    step(1'b1, 1'b1, {3'd1, 16'hdead}, 1'b1, {3'd2, 16'hbeef});
    idle_steps(1);

    // Single write: 2-edge latency into rf
    step(1'b0, 1'b1, {3'd3, 16'h1234}, 1'b0, '0);
    idle_steps(2);
    chk("single_rf_r3", 32'(rf_obs[3]), 32'h1234);
    idle_steps(1);

    // Contention from reset: requester 0 wins first
    step(1'b1, 1'b0, '0, 1'b0, '0);
    wlog.delete();
    f0 = '{ {3'd1, 16'hA001}, {3'd2, 16'hA002}, {3'd3, 16'hA003} };
    f1 = '{ {3'd5, 16'hB005}, {3'd6, 16'hB006}, {3'd7, 16'hB007} };
    run_feed(10);
    exp_seq = '{ {3'd1, 16'hA001}, {3'd5, 16'hB005}, {3'd2, 16'hA002},
                 {3'd6, 16'hB006}, {3'd3, 16'hA003}, {3'd7, 16'hB007} };
    chk("contention_count", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) chk("contention_order", 32'(wlog[i]), 32'(exp_seq[i]));

    // Full buffer on requester 1 and a dropped request
    step(1'b1, 1'b0, '0, 1'b0, '0);
    wlog.delete();
    step(1'b0, 1'b1, {3'd0, 16'h0a00}, 1'b1, {3'd1, 16'hC001});
    step(1'b0, 1'b1, {3'd0, 16'h0a01}, 1'b1, {3'd1, 16'hC002});
    step(1'b0, 1'b1, {3'd0, 16'h0a02}, 1'b1, {3'd1, 16'hC003});
    step(1'b0, 1'b0, '0, 1'b1, {3'd1, 16'hC004});
    idle_steps(6);
    hits = 0;
    foreach (wlog[i]) if (wlog[i] == {3'd1, 16'hC003}) hits++;
    chk("dropped_absent", 32'(hits), 32'd0);
    chk("rf_r1_last", 32'(rf_obs[1]), 32'hC004);

    // Same-register race right after reset
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, {3'd4, 16'h1111}, 1'b1, {3'd4, 16'h2222});
    idle_steps(3);
    chk("race_rf_r4", 32'(rf_obs[4]), 32'h2222);

    // Reset mid-operation with buffered entries
    step(1'b0, 1'b1, {3'd5, 16'h5500}, 1'b1, {3'd6, 16'h6600});
    step(1'b0, 1'b1, {3'd5, 16'h5501}, 1'b1, {3'd6, 16'h6601});
    step(1'b1, 1'b0, '0, 1'b0, '0);
    idle_steps(2);
    step(1'b0, 1'b1, {3'd7, 16'h7777}, 1'b0, '0);
    idle_steps(2);
    chk("post_reset_rf_r7", 32'(rf_obs[7]), 32'h7777);

    // Random traffic, occasionally ignoring ready or pulsing reset
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(63) == 0);
      v0 = ($urandom_range(3) != 0);
      v1 = ($urandom_range(2) != 0);
      step(r, v0, 19'($urandom), v1, 19'($urandom));
    end
    idle_steps(4);
    for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf_obs[i]), 32'(rf_exp[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
